lab4_branch_pht_sched: RTL and testbench
========================================

Name: lab4_branch_pht_sched

Overview:
- Sequences a single-ported Pattern History Table (PHT) for the gshare-style global predictor, and shares it between two requesters: fetch-stage predict lookups and execute-stage 2-bit counter updates.
- Owns the global history register (GHR) and the index hash.
- Runs a post-reset initialisation sweep of the PHT.
- Updates are read-modify-write; a starvation counter bounds how long predict priority can block an update.

Parameters:
- PHT_SIZE, 2048, number of PHT entries; power of two, >=4. Localparam IDX_W = $clog2(PHT_SIZE).
- STARVE_LIMIT, 4, maximum consecutive predict grants while an update is pending; >=1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pred_req_val  in  1  predict request valid
- pred_req_rdy  out  1  predict request accepted this cycle
- pred_req_pc  in  32  PC to predict
- pred_resp_val  out  1  prediction valid; no backpressure
- pred_resp_taken  out  1  predicted direction (counter MSB)
- upd_req_val  in  1  update request valid
- upd_req_rdy  out  1  update request accepted this cycle
- upd_req_pc  in  32  resolved branch PC
- upd_req_taken  in  1  resolved direction
- pht_en  out  1  PHT access enable
- pht_wen  out  1  PHT write enable (valid only with pht_en)
- pht_addr  out  IDX_W  PHT index
- pht_wdata  out  2  counter write data
- pht_rdata  in  2  read data; valid the cycle after a read (pht_en=1, pht_wen=0)
- ghr  out  IDX_W  current global history (debug/observe)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on reset.
- Index hash: idx(pc) = pc[IDX_W+1:2] XOR ghr.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Taken: +1, saturating at 11.
  - Not taken: -1, saturating at 00.
- States: INIT, IDLE, UPD_WR.
- Reset: while reset=1, the following are all 0:
  - pht_en, pht_wen
  - both rdy outputs
  - pred_resp_val
- Registered state after reset: state=INIT, init_idx=0, ghr=0, starve_cnt=0, resp pending cleared.
- INIT:
  - Each cycle: pht_en=1, pht_wen=1, pht_addr=init_idx, pht_wdata=01.
  - init_idx increments every cycle; at init_idx=PHT_SIZE-1 the next state is IDLE.
  - Both rdy=0. Duration is exactly PHT_SIZE cycles.
- IDLE grant rule (combinational, one grant per cycle):
  - force_upd = upd_req_val && starve_cnt==STARVE_LIMIT.
  - Predict granted if pred_req_val && !force_upd. Otherwise update granted if upd_req_val.
  - rdy is asserted only to the granted requester.
- Predict grant:
  - Same cycle: pht_en=1, pht_wen=0, pht_addr=idx(pred_req_pc).
  - Next cycle: pred_resp_val=1, pred_resp_taken=pht_rdata[1].
  - Back-to-back predicts are legal, one response per cycle.
  - State stays IDLE.
- Update grant:
  - Same cycle: read at idx(upd_req_pc); latch index and taken; next state UPD_WR.
- UPD_WR:
  - pht_en=1, pht_wen=1, pht_addr=latched idx, pht_wdata=sat(pht_rdata, taken).
  - ghr <= {ghr[IDX_W-2:0], taken}.
  - Both rdy=0. Next state IDLE.
  - A predict response due this cycle still fires; it is impossible anyway, because the previous cycle was an update grant.
- starve_cnt:
  - Increments on a predict grant while upd_req_val=1.
  - Clears on an update grant or whenever upd_req_val=0.
  - Never exceeds STARVE_LIMIT.
- Ordering: a predict issued in the cycle after UPD_WR sees the written value and the new GHR.
- Reset mid-operation (any state): the write in that cycle is suppressed, any pending response is dropped, and INIT restarts at index 0.

Decomposition:
- Package lab4_branch_pkg holds:
  - State enum (INIT, IDLE, UPD_WR).
  - Counter constants (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST).
  - Saturating-update function.
- Sub-module lab4_branch_ghr: IDX_W shift register with clk, reset, shift_en, shift_in, and ghr out.

Test Plan (PHT_SIZE=16, STARVE_LIMIT=4):
- Reset, then release -> 16 cycles of pht_wen=1 with addr 0..15 and wdata=01, rdy=0 throughout; pred_req_rdy=1 on cycle 17.
- Predict pc=0x10 after INIT -> pht_addr=4 with wen=0 the same cycle; next cycle pred_resp_val=1, pred_resp_taken=0.
- Update pc=0x10 taken -> read addr 4, then the next cycle writes addr 4 wdata=10 and ghr becomes 0001. Then predict pc=0x14 -> addr 4, taken=1.
- Three not-taken updates at pc=0x10 from INIT -> writes at addr 4 are 00, 00, 00 (saturation); ghr stays 0; each update takes 2 cycles with rdy=0 in UPD_WR.
- pred_req_val and upd_req_val both held high -> 4 consecutive predict grants, then 5th cycle upd_req_rdy=1 and pred_req_rdy=0, then one UPD_WR cycle with both rdy=0, then starve_cnt=0 and predict wins again.
- Assert reset during UPD_WR -> no write that cycle, pred_resp_val=0, ghr=0, INIT sweep restarts at addr 0.

Source files
------------

// File: rtl/lab4_branch_pkg.sv
// Shared types, counter encodings and the 2-bit saturating update for the PHT scheduler.
package lab4_branch_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StUpdWr
  } pht_state_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lab4_branch_ghr.sv
// Global history shift register; newest outcome enters at bit 0.
module lab4_branch_ghr #(
  parameter int unsigned IDX_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [IDX_W-1:0] ghr
);

  logic [IDX_W-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (shift_en) begin
      ghr_d = {ghr_q[IDX_W-2:0], shift_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr = ghr_q;

endmodule

// File: rtl/lab4_branch_pht_sched.sv
// Single-ported gshare PHT sequencer: init sweep, predict/update arbitration with
// starvation bound, and read-modify-write counter updates.
module lab4_branch_pht_sched
  import lab4_branch_pkg::*;
#(
  parameter int unsigned PHT_SIZE     = 2048,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned IDX_W       = $clog2(PHT_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_req_val,
  output logic             pred_req_rdy,
  input  logic [31:0]      pred_req_pc,
  output logic             pred_resp_val,
  output logic             pred_resp_taken,
  input  logic             upd_req_val,
  output logic             upd_req_rdy,
  input  logic [31:0]      upd_req_pc,
  input  logic             upd_req_taken,
  output logic             pht_en,
  output logic             pht_wen,
  output logic [IDX_W-1:0] pht_addr,
  output logic [1:0]       pht_wdata,
  input  logic [1:0]       pht_rdata,
  output logic [IDX_W-1:0] ghr
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHT_SIZE - 1);

  pht_state_e       state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             resp_pend_q, resp_pend_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             upd_taken_q, upd_taken_d;

  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic             force_upd, pred_grant, upd_grant, ghr_shift;

  // PC bits outside the hash window carry no index information.
  logic unused_pc;
  assign unused_pc = ^{pred_req_pc[31:IDX_W+2], pred_req_pc[1:0],
                       upd_req_pc[31:IDX_W+2], upd_req_pc[1:0]};

  assign pred_idx  = pred_req_pc[IDX_W+1:2] ^ ghr;
  assign upd_idx   = upd_req_pc[IDX_W+1:2] ^ ghr;
  assign force_upd = upd_req_val && (starve_q == STARVE_MAX);

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    upd_idx_d    = upd_idx_q;
    upd_taken_d  = upd_taken_q;
    pred_grant   = 1'b0;
    upd_grant    = 1'b0;
    ghr_shift    = 1'b0;
    pht_en       = 1'b0;
    pht_wen      = 1'b0;
    pht_addr     = '0;
    pht_wdata    = CTR_SNT;
    pred_req_rdy = 1'b0;
    upd_req_rdy  = 1'b0;

    unique case (state_q)
      StInit: begin
        pht_en     = 1'b1;
        pht_wen    = 1'b1;
        pht_addr   = init_idx_q;
        pht_wdata  = CTR_WNT;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (pred_req_val && !force_upd) begin
          pred_grant   = 1'b1;
          pred_req_rdy = 1'b1;
          pht_en       = 1'b1;
          pht_addr     = pred_idx;
        end else if (upd_req_val) begin
          upd_grant   = 1'b1;
          upd_req_rdy = 1'b1;
          pht_en      = 1'b1;
          pht_addr    = upd_idx;
          upd_idx_d   = upd_idx;
          upd_taken_d = upd_req_taken;
          state_d     = StUpdWr;
        end
      end
      StUpdWr: begin
        pht_en    = 1'b1;
        pht_wen   = 1'b1;
        pht_addr  = upd_idx_q;
        pht_wdata = ctr_sat_update(pht_rdata, upd_taken_q);
        ghr_shift = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StInit;
    endcase

    // Reset silences the port, including a write already in flight.
    if (reset) begin
      pht_en       = 1'b0;
      pht_wen      = 1'b0;
      pred_req_rdy = 1'b0;
      upd_req_rdy  = 1'b0;
      ghr_shift    = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!upd_req_val || upd_grant) begin
      starve_d = '0;
    end else if (pred_grant) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign resp_pend_d = pred_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInit;
      init_idx_q  <= '0;
      starve_q    <= '0;
      resp_pend_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      starve_q    <= starve_d;
      resp_pend_q <= resp_pend_d;
      upd_idx_q   <= upd_idx_d;
      upd_taken_q <= upd_taken_d;
    end
  end

  assign pred_resp_val   = resp_pend_q && !reset;
  assign pred_resp_taken = pred_resp_val && pht_rdata[1];

  lab4_branch_ghr #(
    .IDX_W(IDX_W)
  ) u_ghr (
    .clk     (clk),
    .reset   (reset),
    .shift_en(ghr_shift),
    .shift_in(upd_taken_q),
    .ghr     (ghr)
  );

endmodule

// File: tb/tb_lab4_branch_pht_sched.sv
// Randomised bench: a behavioural PHT/GHR/arbiter model predicts every port each cycle.
module tb_lab4_branch_pht_sched;

  localparam int PHT_SIZE     = 16;
  localparam int STARVE_LIMIT = 4;
  localparam int IDX_W        = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             pred_req_val, pred_req_rdy, pred_resp_val, pred_resp_taken;
  logic [31:0]      pred_req_pc;
  logic             upd_req_val, upd_req_rdy, upd_req_taken;
  logic [31:0]      upd_req_pc;
  logic             pht_en, pht_wen;
  logic [IDX_W-1:0] pht_addr, ghr;
  logic [1:0]       pht_wdata, pht_rdata;

  lab4_branch_pht_sched #(
    .PHT_SIZE    (PHT_SIZE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pred_req_val   (pred_req_val),
    .pred_req_rdy   (pred_req_rdy),
    .pred_req_pc    (pred_req_pc),
    .pred_resp_val  (pred_resp_val),
    .pred_resp_taken(pred_resp_taken),
    .upd_req_val    (upd_req_val),
    .upd_req_rdy    (upd_req_rdy),
    .upd_req_pc     (upd_req_pc),
    .upd_req_taken  (upd_req_taken),
    .pht_en         (pht_en),
    .pht_wen        (pht_wen),
    .pht_addr       (pht_addr),
    .pht_wdata      (pht_wdata),
    .pht_rdata      (pht_rdata),
    .ghr            (ghr)
  );

  always #5 clk = ~clk;

  // Single-port SRAM the scheduler drives.
  logic [1:0] mem [PHT_SIZE];
  initial begin
    for (int i = 0; i < PHT_SIZE; i++) mem[i] = 2'b00;
    pht_rdata = 2'b00;
  end
  always @(posedge clk) begin
    if (pht_en && pht_wen) mem[pht_addr] <= pht_wdata;
    else if (pht_en) pht_rdata <= mem[pht_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int  m_pht [PHT_SIZE];
  int  m_ghr;
  int  m_starve;
  int  m_init_left;
  bit  m_wr_pend;
  int  m_wr_idx;
  bit  m_wr_taken;
  bit  m_resp_due;
  int  m_resp_taken;

  function automatic int sat(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic int hash(input logic [31:0] pc, input int g);
    return ((pc >> 2) % PHT_SIZE) ^ g;
  endfunction

  task automatic step(input bit rst, input bit pv, input logic [31:0] ppc,
                      input bit uv, input logic [31:0] upc, input bit ut);
    int e_en, e_wen, e_addr, e_wdata, e_prdy, e_urdy;
    bit check_addr, check_wdata;
    @(negedge clk);
    reset = rst; pred_req_val = pv; pred_req_pc = ppc;
    upd_req_val = uv; upd_req_pc = upc; upd_req_taken = ut;
    #1;
    e_en = 0; e_wen = 0; e_addr = 0; e_wdata = 0; e_prdy = 0; e_urdy = 0;
    check_addr = 0; check_wdata = 0;
    if (rst) begin
      check("rst_en", pht_en, 0);
      check("rst_wen", pht_wen, 0);
      check("rst_prdy", pred_req_rdy, 0);
      check("rst_urdy", upd_req_rdy, 0);
      check("rst_resp", pred_resp_val, 0);
      m_ghr = 0; m_starve = 0; m_init_left = PHT_SIZE;
      m_wr_pend = 0; m_resp_due = 0;
      return;
    end
    check("ghr", ghr, m_ghr);
    check("resp_val", pred_resp_val, m_resp_due);
    if (m_resp_due) check("resp_taken", pred_resp_taken, m_resp_taken);
    m_resp_due = 0;
    if (m_init_left > 0) begin
      e_en = 1; e_wen = 1; e_addr = PHT_SIZE - m_init_left; e_wdata = 1;
      check_addr = 1; check_wdata = 1;
      m_pht[e_addr] = 1;
      m_init_left--;
      if (!uv) m_starve = 0;
    end else if (m_wr_pend) begin
      e_en = 1; e_wen = 1; e_addr = m_wr_idx; e_wdata = sat(m_pht[m_wr_idx], m_wr_taken);
      check_addr = 1; check_wdata = 1;
      m_pht[m_wr_idx] = e_wdata;
      m_ghr = ((m_ghr << 1) | int'(m_wr_taken)) % PHT_SIZE;
      m_wr_pend = 0;
      if (!uv) m_starve = 0;
    end else if (pv && !(uv && m_starve == STARVE_LIMIT)) begin
      e_en = 1; e_prdy = 1; e_addr = hash(ppc, m_ghr); check_addr = 1;
      m_resp_due = 1; m_resp_taken = (m_pht[e_addr] >= 2) ? 1 : 0;
      m_starve = uv ? m_starve + 1 : 0;
    end else if (uv) begin
      e_en = 1; e_urdy = 1; e_addr = hash(upc, m_ghr); check_addr = 1;
      m_wr_pend = 1; m_wr_idx = e_addr; m_wr_taken = ut;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
    check("pht_en", pht_en, e_en);
    check("pred_rdy", pred_req_rdy, e_prdy);
    check("upd_rdy", upd_req_rdy, e_urdy);
    if (e_en) check("pht_wen", pht_wen, e_wen);
    if (check_addr) check("pht_addr", pht_addr, e_addr);
    if (check_wdata) check("pht_wdata", pht_wdata, e_wdata);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; pred_req_val = 0; upd_req_val = 0; upd_req_taken = 0;
    pred_req_pc = 0; upd_req_pc = 0;
    for (int i = 0; i < PHT_SIZE; i++) m_pht[i] = 0;
    m_ghr = 0; m_starve = 0; m_init_left = PHT_SIZE; m_wr_pend = 0; m_resp_due = 0;
    m_wr_idx = 0; m_wr_taken = 0; m_resp_taken = 0;

    repeat (3) step(1, 0, 0, 0, 0, 0);
    // Requests during the sweep must be ignored.
    for (int i = 0; i < PHT_SIZE; i++) step(0, 1, 32'h10, 1, 32'h20, 1);
    step(0, 1, 32'h10, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h10, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h14, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Not-taken saturation from a fresh sweep.
    step(1, 0, 0, 0, 0, 0);
    idle_cycles(PHT_SIZE);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 32'h10, 0);
      step(0, 0, 0, 0, 0, 0);
    end

    // Starvation: both held high.
    for (int i = 0; i < 14; i++) step(0, 1, 32'h40 + 4 * i, 1, 32'h10, 1);

    // Reset landing on the write cycle.
    idle_cycles(2);
    step(0, 0, 0, 1, 32'h18, 1);
    step(1, 0, 0, 0, 0, 0);
    idle_cycles(PHT_SIZE + 2);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 2) != 0), $urandom, $urandom_range(0, 1) == 1);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
